// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction-memory loader. Assembles a byte stream
//                into little-endian words (header N, N data words, checksum),
//                writes the data words into instruction memory, verifies an
//                additive checksum and holds the core in reset until the
//                image is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int              MAX_WORDS = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_rx_valid,
    input  logic [7:0]      i_rx_data,
    output logic            o_rx_ready,
    output logic            o_im_wvalid,
    output logic [XLEN-1:0] o_im_waddr,
    output logic [XLEN-1:0] o_im_wdata,
    output logic            o_core_rst,
    output logic            o_done,
    output logic            o_err,
    output logic [XLEN-1:0] o_words_loaded
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_hdr  = 3'd1;
    localparam logic [2:0] c_st_data = 3'd2;
    localparam logic [2:0] c_st_csum = 3'd3;
    localparam logic [2:0] c_st_done = 3'd4;
    localparam logic [2:0] c_st_err  = 3'd5;

    localparam logic [XLEN-1:0] c_max_words = XLEN'(MAX_WORDS);
    localparam logic [XLEN-1:0] c_one       = XLEN'(1);

    logic [2:0]      r_state;
    logic [1:0]      r_byte_cnt;
    logic [23:0]     r_asm;        // lower three bytes of the word in flight
    logic [XLEN-1:0] r_count;      // header word count N
    logic [XLEN-1:0] r_idx;
    logic [XLEN-1:0] r_sum;
    logic            r_wvalid;
    logic [XLEN-1:0] r_waddr;
    logic [XLEN-1:0] r_wdata;

    logic            w_ready;
    logic            w_fire;
    logic            w_word_done;
    logic [XLEN-1:0] w_word;
    logic [XLEN-1:0] w_idx_next;

    assign w_ready     = (r_state == c_st_hdr) || (r_state == c_st_data) ||
                         (r_state == c_st_csum);
    assign w_fire      = i_rx_valid && w_ready;
    assign w_word_done = w_fire && (r_byte_cnt == 2'd3);
    // The 4th byte goes straight into the top lane so the word is usable at
    // the same edge that accepts it.
    assign w_word      = {i_rx_data, r_asm};
    assign w_idx_next  = r_idx + c_one;

    // Byte assembly, FSM sequencing, index and running checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_byte_cnt <= 2'd0;
            r_asm      <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_sum      <= '0;
        end else begin
            if (r_state == c_st_idle) begin
                r_state <= c_st_hdr;
            end
            if (w_fire) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                case (r_byte_cnt)
                    2'd0:    r_asm[7:0]   <= i_rx_data;
                    2'd1:    r_asm[15:8]  <= i_rx_data;
                    2'd2:    r_asm[23:16] <= i_rx_data;
                    default: ;
                endcase
            end
            if (w_word_done) begin
                case (r_state)
                    c_st_hdr: begin
                        r_count <= w_word;
                        if (w_word > c_max_words) begin
                            r_state <= c_st_err;
                        end else if (w_word == '0) begin
                            r_state <= c_st_csum;
                        end else begin
                            r_state <= c_st_data;
                        end
                    end
                    c_st_data: begin
                        r_sum <= r_sum + w_word;
                        r_idx <= w_idx_next;
                        if (w_idx_next == r_count) begin
                            r_state <= c_st_csum;
                        end
                    end
                    c_st_csum: begin
                        r_state <= (w_word == r_sum) ? c_st_done : c_st_err;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Registered memory write port: one-cycle strobe per completed data word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wvalid <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            r_wvalid <= 1'b0;
            if (w_word_done && (r_state == c_st_data)) begin
                r_wvalid <= 1'b1;
                r_waddr  <= BASE_ADDR + {r_idx[XLEN-3:0], 2'b00};
                r_wdata  <= w_word;
            end
        end
    end

    assign o_rx_ready     = w_ready;
    assign o_im_wvalid    = r_wvalid;
    assign o_im_waddr     = r_waddr;
    assign o_im_wdata     = r_wdata;
    assign o_core_rst     = (r_state != c_st_done);
    assign o_done         = (r_state == c_st_done);
    assign o_err          = (r_state == c_st_err);
    assign o_words_loaded = r_idx;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader. Expected memory writes
//                are queued as data words are driven and compared when the
//                write strobe fires. A second instance with a non-zero base
//                address receives the same stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    logic        rx_ready_a, wvalid_a, core_rst_a, done_a, err_a;
    logic [31:0] waddr_a, wdata_a, words_a;
    logic        rx_ready_b, wvalid_b, core_rst_b, done_b, err_b;
    logic [31:0] waddr_b, wdata_b, words_b;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_addr_a[$];
    logic [31:0] exp_data_a[$];
    logic [31:0] exp_addr_b[$];
    logic [31:0] exp_data_b[$];
    logic [31:0] img[4];

    imem_loader u_dut_a (
        .clk(clk), .rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_rx_ready(rx_ready_a), .o_im_wvalid(wvalid_a), .o_im_waddr(waddr_a),
        .o_im_wdata(wdata_a), .o_core_rst(core_rst_a), .o_done(done_a),
        .o_err(err_a), .o_words_loaded(words_a)
    );

    imem_loader #(.BASE_ADDR(32'h0000_0100)) u_dut_b (
        .clk(clk), .rst(rst), .i_rx_valid(rx_valid), .i_rx_data(rx_data),
        .o_rx_ready(rx_ready_b), .o_im_wvalid(wvalid_b), .o_im_waddr(waddr_b),
        .o_im_wdata(wdata_b), .o_core_rst(core_rst_b), .o_done(done_b),
        .o_err(err_b), .o_words_loaded(words_b)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Write-port monitors for both instances.
    always @(negedge clk) begin
        if (wvalid_a) begin
            if (exp_addr_a.size() == 0) check_eq("wr_unexpected_a", 32'(wvalid_a), 32'd0);
            else begin
                check_eq("waddr_a", waddr_a, exp_addr_a.pop_front());
                check_eq("wdata_a", wdata_a, exp_data_a.pop_front());
            end
        end
        if (wvalid_b) begin
            if (exp_addr_b.size() == 0) check_eq("wr_unexpected_b", 32'(wvalid_b), 32'd0);
            else begin
                check_eq("waddr_b", waddr_b, exp_addr_b.pop_front());
                check_eq("wdata_b", wdata_b, exp_data_b.pop_front());
            end
        end
    end

    // Drive one byte; starts and ends on a falling edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 50; t++) begin
            if (rx_ready_a) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_eq("rx_timeout", 32'(rx_ready_a), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit is_data,
                             input logic [31:0] idx, input int maxgap);
        logic [31:0] v;
        v = w;
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && is_data) begin
                exp_addr_a.push_back(idx << 2);
                exp_data_a.push_back(v);
                exp_addr_b.push_back(32'h100 + (idx << 2));
                exp_data_b.push_back(v);
            end
            send_byte(v[8*i +: 8], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
        end
    endtask

    task automatic load_img(input int n, input logic [31:0] csum, input int maxgap);
        send_word(32'(n), 1'b0, 32'd0, maxgap);
        for (int i = 0; i < n; i++) send_word(img[i], 1'b1, 32'(i), maxgap);
        send_word(csum, 1'b0, 32'd0, maxgap);
    endtask

    function automatic logic [31:0] img_sum(input int n);
        logic [31:0] s;
        s = 32'd0;
        for (int i = 0; i < n; i++) s = s + img[i];
        return s;
    endfunction

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"},    32'(rx_ready_a), 32'd0);
        check_eq({tag, "_wvalid"},   32'(wvalid_a),   32'd0);
        check_eq({tag, "_waddr"},    waddr_a,         32'd0);
        check_eq({tag, "_wdata"},    wdata_a,         32'd0);
        check_eq({tag, "_core_rst"}, 32'(core_rst_a), 32'd1);
        check_eq({tag, "_done"},     32'(done_a),     32'd0);
        check_eq({tag, "_err"},      32'(err_a),      32'd0);
        check_eq({tag, "_words"},    words_a,         32'd0);
    endtask

    // Pulse reset, then confirm ready rises one cycle after deassertion.
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("ready_in_idle", 32'(rx_ready_a), 32'd0);
        @(negedge clk);
        check_eq("ready_after_idle", 32'(rx_ready_a), 32'd1);
    endtask

    task automatic offer_extra(input string tag);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check_eq(tag, 32'(rx_ready_a), 32'd0);
        end
        rx_valid = 1'b0;
    endtask

    task automatic check_final(input string tag, input bit exp_done, input logic [31:0] exp_words);
        check_eq({tag, "_done"},     32'(done_a),     32'(exp_done));
        check_eq({tag, "_err"},      32'(err_a),      32'(!exp_done));
        check_eq({tag, "_core_rst"}, 32'(core_rst_a), 32'(!exp_done));
        check_eq({tag, "_ready"},    32'(rx_ready_a), 32'd0);
        check_eq({tag, "_words"},    words_a,         exp_words);
        check_eq({tag, "_qempty"},   32'(exp_addr_a.size() + exp_addr_b.size()), 32'd0);
    endtask

    initial begin
        img[0] = 32'h0050_0093;
        img[1] = 32'h00A0_0113;
        img[2] = 32'h0020_81B3;
        img[3] = 32'h0000_0000;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("rst0");
        rst = 1'b0;
        check_eq("ready_in_idle", 32'(rx_ready_a), 32'd0);
        @(negedge clk);
        check_eq("ready_after_idle", 32'(rx_ready_a), 32'd1);

        // Good 3-word image, continuous valid.
        load_img(3, img_sum(3), 0);
        check_final("good", 1'b1, 32'd3);
        offer_extra("good_extra_ready");

        // Checksum mismatch.
        do_reset();
        load_img(3, 32'h0000_0000, 0);
        check_final("badsum", 1'b0, 32'd3);
        offer_extra("badsum_extra_ready");

        // Oversized header.
        do_reset();
        send_word(32'd1025, 1'b0, 32'd0, 0);
        check_final("oversize", 1'b0, 32'd0);

        // Header exactly MAX_WORDS is accepted.
        do_reset();
        send_word(32'd1024, 1'b0, 32'd0, 0);
        check_eq("max_hdr_err",   32'(err_a),      32'd0);
        check_eq("max_hdr_ready", 32'(rx_ready_a), 32'd1);

        // Empty image.
        do_reset();
        load_img(0, 32'd0, 0);
        check_final("empty", 1'b1, 32'd0);

        // Single word; second instance writes at its base address.
        do_reset();
        img[3] = 32'hDEAD_BEEF;
        img[0] = img[3];
        load_img(1, 32'hDEAD_BEEF, 0);
        check_final("one", 1'b1, 32'd1);
        check_eq("one_b_done", 32'(done_b), 32'd1);
        check_eq("one_b_words", words_b, 32'd1);
        img[0] = 32'h0050_0093;

        // Random gaps between bytes.
        do_reset();
        load_img(3, img_sum(3), 5);
        check_final("gaps", 1'b1, 32'd3);

        // Reset after the 2nd byte of data word 2, then reload.
        do_reset();
        send_word(32'd3, 1'b0, 32'd0, 0);
        send_word(img[0], 1'b1, 32'd0, 0);
        send_word(img[1], 1'b1, 32'd1, 0);
        send_byte(img[2][7:0], 0);
        send_byte(img[2][15:8], 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("midrst_qempty", 32'(exp_addr_a.size()), 32'd0);
        check_eq("midrst_words", words_a, 32'd0);
        load_img(3, img_sum(3), 0);
        check_final("reload", 1'b1, 32'd3);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
